// File: rtl/iomem_mailbox_pkg.sv
// rtl/iomem_mailbox_pkg.sv - register map and status layout shared by the mailbox files
package iomem_mailbox_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_TX_COUNT  = 8;
  localparam int STAT_RX_COUNT  = 16;

  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/iomem_mailbox_fifo.sv
// rtl/iomem_mailbox_fifo.sv - synchronous FIFO; full/empty gate push/pop on pre-edge state
module iomem_mailbox_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iomem_mailbox.sv
// rtl/iomem_mailbox.sv - iomem responder bridging CPU word accesses to TX/RX word streams
module iomem_mailbox
  import iomem_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready,
  output logic        irq
);

  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [31:0]         rx_head;
  logic [1:0]          irq_en;
  logic                sel, is_write, complete;
  logic                tx_push, tx_pop, rx_push, rx_pop;
  logic [1:0]          reg_idx;
  logic [31:0]         rd_value;
  logic [31:0]         status_word;
  logic                addr_unused;

  assign addr_unused = ^{iomem_addr[7:4], iomem_addr[1:0]};

  assign sel      = iomem_valid & (iomem_addr[31:8] == BASE_ADDR[31:8]) & ~iomem_ready;
  assign is_write = |iomem_wstrb;
  assign reg_idx  = iomem_addr[3:2];

  // A TXDATA write into a full FIFO is the only access that stalls.
  assign complete = sel & ~((reg_idx == REG_TXDATA) & is_write & tx_full);
  assign tx_push  = complete & (reg_idx == REG_TXDATA) & is_write;
  assign rx_pop   = complete & (reg_idx == REG_RXDATA) & ~is_write & ~rx_empty;
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  always_comb begin
    status_word = '0;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_TX_EMPTY] = tx_empty;
    status_word[STAT_RX_FULL]  = rx_full;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_TX_COUNT +: 8] = 8'(tx_count);
    status_word[STAT_RX_COUNT +: 8] = 8'(rx_count);
  end

  always_comb begin
    rd_value = '0;
    case (reg_idx)
      REG_RXDATA: rd_value = rx_empty ? RX_EMPTY_WORD : rx_head;
      REG_STATUS: rd_value = status_word;
      REG_IRQ_EN: rd_value = {30'd0, irq_en};
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
    end else begin
      iomem_ready <= complete;
      iomem_rdata <= (complete & ~is_write) ? rd_value : '0;
      if (complete && reg_idx == REG_IRQ_EN && iomem_wstrb[0]) begin
        irq_en <= iomem_wdata[1:0];
      end
      irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end

  iomem_mailbox_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (iomem_wdata),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  iomem_mailbox_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_iomem_mailbox.sv
// tb/tb_iomem_mailbox.sv - queue-model bench with directed mailbox scenarios
module tb_iomem_mailbox;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = 32'd0;
  logic        rx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  iomem_mailbox dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: two word queues, the enable bits and the bus reply.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [1:0]  m_en = 2'd0;
  bit          m_ready = 0;
  bit          m_irq = 0;
  logic [31:0] m_rdata = 32'd0;
  bit          m_live = 0;

  task automatic model_step();
    bit          wr, hit, done, do_txpush, do_rxpop;
    int          ntx, nrx;
    logic [31:0] rd;
    logic [1:0]  en_next;
    if (reset) begin
      txq.delete(); rxq.delete();
      m_en = 0; m_ready = 0; m_rdata = 0; m_irq = 0; m_live = 1;
    end else begin
      wr = |iomem_wstrb;
      hit = iomem_valid && (iomem_addr[31:8] == 24'h030000) && !m_ready;
      ntx = txq.size(); nrx = rxq.size();
      done = 0; do_txpush = 0; do_rxpop = 0; rd = 0; en_next = m_en;
      if (hit) begin
        case (iomem_addr[3:2])
          2'd0: if (!wr) done = 1; else if (ntx < 8) begin done = 1; do_txpush = 1; end
          2'd1: begin
            done = 1;
            if (!wr) begin
              if (nrx == 0) rd = 32'hFFFF_FFFF;
              else begin rd = rxq[0]; do_rxpop = 1; end
            end
          end
          2'd2: begin
            done = 1;
            if (!wr) rd = {8'h0, 8'(nrx), 8'(ntx), 4'h0, nrx == 0, nrx == 8, ntx == 0, ntx == 8};
          end
          default: begin
            done = 1;
            if (!wr) rd = {30'd0, m_en};
            else if (iomem_wstrb[0]) en_next = iomem_wdata[1:0];
          end
        endcase
      end
      m_irq = (m_en[0] && nrx != 0) || (m_en[1] && ntx == 0);
      if (tx_ready && ntx > 0) void'(txq.pop_front());
      if (do_txpush) txq.push_back(iomem_wdata);
      if (do_rxpop) void'(rxq.pop_front());
      if (rx_valid && nrx < 8) rxq.push_back(rx_data);
      m_ready = done; m_rdata = rd; m_en = en_next;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("iomem_ready", {31'd0, iomem_ready}, {31'd0, m_ready});
      if (m_ready) chk("iomem_rdata", iomem_rdata, m_rdata);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, txq.size() > 0});
      if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() < 8});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r, output int cyc);
    bit got;
    @(negedge clk);
    iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
    cyc = 0; r = 0; got = 0;
    repeat (20) begin
      @(negedge clk);
      cyc++;
      if (iomem_ready) begin r = iomem_rdata; got = 1; break; end
    end
    iomem_valid = 1'b0;
    if (!got) chk("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [31:0] A_TX = 32'h0300_0000;
  localparam logic [31:0] A_RX = 32'h0300_0004;
  localparam logic [31:0] A_ST = 32'h0300_0008;
  localparam logic [31:0] A_IE = 32'h0300_000C;

  initial begin
    logic [31:0] r;
    int cyc;
    bit seen;

    do_reset();
    chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    bus(A_TX, 4'hF, 32'hDEAD_BEEF, r, cyc);
    chk("tx_latency", cyc, 32'd1);
    chk("tx_head_valid", {31'd0, tx_valid}, 32'd1);
    chk("tx_head_data", tx_data, 32'hDEAD_BEEF);
    bus(A_ST, 4'h0, 32'd0, r, cyc);
    chk("status_one", r, 32'h0000_0108);

    // Valid held one extra cycle past completion, through an aliased address.
    @(negedge clk);
    iomem_addr = 32'h0300_0010; iomem_wstrb = 4'hF; iomem_wdata = 32'hCAFE_0001; iomem_valid = 1'b1;
    @(negedge clk);
    chk("held_first_ready", {31'd0, iomem_ready}, 32'd1);
    @(negedge clk);
    iomem_valid = 1'b0;
    bus(A_ST, 4'h0, 32'd0, r, cyc);
    chk("held_one_push", r, 32'h0000_0208);

    do_reset();
    for (int i = 0; i < 8; i++) bus(A_TX, 4'hF, i + 1, r, cyc);
    @(negedge clk);
    iomem_addr = A_TX; iomem_wstrb = 4'hF; iomem_wdata = 32'h0000_0009; iomem_valid = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (iomem_ready) seen = 1; end
    chk("full_stall", {31'd0, seen}, 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    cyc = 1;
    seen = iomem_ready;
    while (!seen && cyc < 6) begin @(negedge clk); cyc++; seen = iomem_ready; end
    iomem_valid = 1'b0;
    chk("full_done", {31'd0, seen}, 32'd1);
    chk("full_done_by_2", {31'd0, cyc <= 2}, 32'd1);
    bus(A_ST, 4'h0, 32'd0, r, cyc);
    chk("full_status", r, 32'h0000_0809);
    chk("full_head", tx_data, 32'd2);

    do_reset();
    bus(A_RX, 4'h0, 32'd0, r, cyc);
    chk("rx_empty_word", r, 32'hFFFF_FFFF);
    chk("rx_empty_latency", cyc, 32'd1);
    @(negedge clk); rx_valid = 1'b1; rx_data = 32'h11;
    @(negedge clk); rx_data = 32'h22;
    @(negedge clk); rx_valid = 1'b0;
    bus(A_RX, 4'h0, 32'd0, r, cyc);
    chk("rx_first", r, 32'h11);
    bus(A_RX, 4'h0, 32'd0, r, cyc);
    chk("rx_second", r, 32'h22);

    bus(A_IE, 4'h1, 32'h1, r, cyc);
    bus(A_IE, 4'h0, 32'd0, r, cyc);
    chk("irq_en_read", r, 32'd1);
    @(negedge clk); rx_valid = 1'b1; rx_data = 32'h33;
    @(negedge clk); rx_valid = 1'b0;
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus(A_RX, 4'h0, 32'd0, r, cyc);
    chk("irq_pop_word", r, 32'h33);
    chk("irq_still", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_clear", {31'd0, irq}, 32'd0);

    @(negedge clk);
    iomem_addr = 32'h0400_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h5555_AAAA; iomem_valid = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (iomem_ready) seen = 1; end
    iomem_valid = 1'b0;
    chk("out_of_window", {31'd0, seen}, 32'd0);

    do_reset();
    bus(A_IE, 4'h1, 32'h3, r, cyc);
    for (int i = 0; i < 8; i++) bus(A_TX, 4'hF, 32'h100 + i, r, cyc);
    @(negedge clk);
    iomem_addr = A_TX; iomem_wstrb = 4'hF; iomem_wdata = 32'h0000_0200; iomem_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; iomem_valid = 1'b0;
    chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, iomem_ready}, 32'd0);
    bus(A_ST, 4'h0, 32'd0, r, cyc);
    chk("rst_mid_status", r, 32'h0000_000A);
    bus(A_IE, 4'h0, 32'd0, r, cyc);
    chk("rst_mid_irq_en", r, 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
